// File: rtl/ifmap_pop_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// token_engine_pkg
//   Types and defaults shared by the token-engine pop sequencers.
//   lane_state_e     : per-lane pop FSM state
//   NUM_FIFO_DEF     : default number of FIFO lanes per bank
//   CNT_W_DEF        : default width of a lane's pop count
//   load_state()     : state a lane enters when a pop order is loaded
// ---------------------------------------------------------------------------
package token_engine_pkg;

   typedef enum logic [1:0] {
      LANE_IDLE = 2'd0,
      LANE_POP  = 2'd1,
      LANE_DONE = 2'd2
   } lane_state_e;

   localparam int NUM_FIFO_DEF = 32;
   localparam int CNT_W_DEF    = 32;

   // A zero-length order completes at once; anything else starts popping.
   function automatic lane_state_e load_state(input logic count_nonzero);
      lane_state_e result;
      if (count_nonzero) begin
         result = LANE_POP;
      end else begin
         result = LANE_DONE;
      end
      return result;
   endfunction

endpackage

// File: rtl/ifmap_pop_sequencer_pop_lane.sv
// ---------------------------------------------------------------------------
// pop_lane
//   One FIFO lane of the pop sequencer: loads a pop order, issues one pop per
//   cycle whenever the FIFO is non-empty and the array is not stalled, and
//   reports completion.
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   need_pop       : load strobe for this lane
//   pop_num        : pop count sampled with need_pop
//   fifo_empty     : FIFO empty flag for this lane
//   stall          : global stall, suppresses pops
//   clear          : synchronous clear back to IDLE (wins over a load)
//   fifo_pop       : pop strobe, combinational from registered state
//   done           : lane is in DONE
//   in_pop         : lane is in POP
//   load_hit_busy  : a load arrived while the lane was still popping
// ---------------------------------------------------------------------------
module pop_lane
   import token_engine_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             need_pop,
   input  logic [CNT_W-1:0] pop_num,
   input  logic             fifo_empty,
   input  logic             stall,
   input  logic             clear,
   output logic             fifo_pop,
   output logic             done,
   output logic             in_pop,
   output logic             load_hit_busy
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   lane_state_e      state;
   lane_state_e      state_next;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] remaining_next;

   assign in_pop        = (state == LANE_POP);
   assign done          = (state == LANE_DONE);
   assign fifo_pop      = in_pop & ~fifo_empty & ~stall;
   // A cleared cycle drops the load, so it is not counted as a collision.
   assign load_hit_busy = need_pop & in_pop & ~clear;

   // Lane state and remaining-count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LANE_IDLE;
         remaining <= CNT_ZERO;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
      end
   end

   // Next-state logic: load, countdown and completion.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      if (clear) begin
         state_next     = LANE_IDLE;
         remaining_next = CNT_ZERO;
      end else begin
         case (state)
            LANE_IDLE, LANE_DONE: begin
               if (need_pop) begin
                  state_next     = load_state(pop_num != CNT_ZERO);
                  remaining_next = pop_num;
               end else begin
                  state_next     = state;
                  remaining_next = remaining;
               end
            end
            LANE_POP: begin
               // Loads during POP are ignored; the count only moves on a pop.
               if (fifo_pop && (remaining != CNT_ZERO)) begin
                  remaining_next = remaining - CNT_ONE;
                  if (remaining == CNT_ONE) begin
                     state_next = LANE_DONE;
                  end else begin
                     state_next = LANE_POP;
                  end
               end else begin
                  state_next     = LANE_POP;
                  remaining_next = remaining;
               end
            end
            default: begin
               state_next     = LANE_IDLE;
               remaining_next = CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: rtl/ifmap_pop_sequencer.sv
// ---------------------------------------------------------------------------
// ifmap_pop_sequencer
//   Executes per-FIFO pop orders for one FIFO bank (ifmap or ipsum) on behalf
//   of the token-engine phase controllers.
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   need_pop_i      : per-lane load strobe
//   pop_num_i       : per-lane pop count, sampled with need_pop_i
//   fifo_empty_i    : per-lane FIFO empty flag
//   stall_i         : global stall, suppresses all pops
//   clear_i         : synchronous clear of all lanes and done bits
//   fifo_pop_o      : per-lane pop strobe
//   done_matrix_o   : per-lane completion level
//   busy_o          : at least one lane is popping
//   err_o           : sticky, a load hit a lane that was still popping
// ---------------------------------------------------------------------------
module ifmap_pop_sequencer
   import token_engine_pkg::*;
#(
   parameter int NUM_FIFO = NUM_FIFO_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_FIFO-1:0]            need_pop_i,
   input  logic [NUM_FIFO-1:0][CNT_W-1:0] pop_num_i,
   input  logic [NUM_FIFO-1:0]            fifo_empty_i,
   input  logic                           stall_i,
   input  logic                           clear_i,
   output logic [NUM_FIFO-1:0]            fifo_pop_o,
   output logic [NUM_FIFO-1:0]            done_matrix_o,
   output logic                           busy_o,
   output logic                           err_o
);

   logic [NUM_FIFO-1:0] lane_in_pop;
   logic [NUM_FIFO-1:0] lane_hit_busy;
   logic                err;

   for (genvar k = 0; k < NUM_FIFO; k++) begin : g_lane
      pop_lane #(
         .CNT_W (CNT_W)
      ) u_lane (
         .clk           (clk),
         .rst           (rst),
         .need_pop      (need_pop_i[k]),
         .pop_num       (pop_num_i[k]),
         .fifo_empty    (fifo_empty_i[k]),
         .stall         (stall_i),
         .clear         (clear_i),
         .fifo_pop      (fifo_pop_o[k]),
         .done          (done_matrix_o[k]),
         .in_pop        (lane_in_pop[k]),
         .load_hit_busy (lane_hit_busy[k])
      );
   end

   assign busy_o = |lane_in_pop;
   assign err_o  = err;

   // Sticky collision flag; only reset clears it, clear_i does not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (|lane_hit_busy) begin
         err <= 1'b1;
      end else begin
         err <= err;
      end
   end

endmodule

// File: tb/tb_ifmap_pop_sequencer.sv
module tb_ifmap_pop_sequencer;

   localparam int N = 32;
   localparam int W = 32;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         need;
   logic [N-1:0][W-1:0]  nums;
   logic [N-1:0]         emp;
   logic                 stall;
   logic                 clr;
   logic [N-1:0]         fifo_pop;
   logic [N-1:0]         done;
   logic                 busy;
   logic                 err;

   // staged stimulus, applied to the DUT at the next falling edge
   logic [N-1:0]         s_need;
   logic [N-1:0][W-1:0]  s_nums;
   logic [N-1:0]         s_emp;
   logic                 s_stall;
   logic                 s_clr;

   // reference model: order-level view of each lane
   int unsigned          m_rem [N];
   bit                   m_active [N];
   bit                   m_done [N];
   bit                   m_err;

   logic [N-1:0]         obs_pop, exp_pop, obs_done, exp_done;
   logic                 obs_busy, exp_busy, obs_err, exp_err;
   int                   pops [N];
   int                   checks;
   int                   failures;

   ifmap_pop_sequencer #(.NUM_FIFO(N), .CNT_W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .need_pop_i    (need),
      .pop_num_i     (nums),
      .fifo_empty_i  (emp),
      .stall_i       (stall),
      .clear_i       (clr),
      .fifo_pop_o    (fifo_pop),
      .done_matrix_o (done),
      .busy_o        (busy),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_rem[k] = 0; m_active[k] = 1'b0; m_done[k] = 1'b0; pops[k] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic clear_pops();
      for (int k = 0; k < N; k++) pops[k] = 0;
   endtask

   // One clock: apply staged inputs, sample DUT, predict, advance the model.
   task automatic tick();
      @(negedge clk);
      need = s_need; nums = s_nums; emp = s_emp; stall = s_stall; clr = s_clr;
      #1;
      obs_pop = fifo_pop; obs_done = done; obs_busy = busy; obs_err = err;
      exp_busy = 1'b0;
      exp_err  = m_err;
      for (int k = 0; k < N; k++) begin
         exp_pop[k]  = m_active[k] && !emp[k] && !stall;
         exp_done[k] = m_done[k];
         exp_busy    = exp_busy | m_active[k];
      end
      for (int k = 0; k < N; k++) begin
         pops[k] += int'(obs_pop[k]);
         if (clr) begin
            m_active[k] = 1'b0; m_done[k] = 1'b0; m_rem[k] = 0;
         end else if (need[k] && !m_active[k]) begin
            m_rem[k]    = nums[k];
            m_active[k] = (nums[k] != 0);
            m_done[k]   = (nums[k] == 0);
         end else begin
            if (need[k]) m_err = 1'b1;
            if (exp_pop[k]) begin
               m_rem[k] = m_rem[k] - 1;
               if (m_rem[k] == 0) begin
                  m_active[k] = 1'b0; m_done[k] = 1'b1;
               end
            end
         end
      end
      s_need = '0; s_clr = 1'b0;
   endtask

   task automatic do_clear();
      s_clr = 1'b1;
      tick();
      clear_pops();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_need = '0; s_nums = '0; s_emp = '0; s_stall = 1'b0; s_clr = 1'b0;
      need = '0; nums = '0; emp = '0; stall = 1'b0; clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({fifo_pop, done, busy, err} !== {(2*N+2){1'b0}}) begin
         failures++;
         $display("FAIL reset_state: pop=%h done=%h busy=%b err=%b, want all 0", fifo_pop, done, busy, err);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_all_one();
      do_clear();
      s_need = '1;
      for (int k = 0; k < N; k++) s_nums[k] = 32'd1;
      tick();
      for (int i = 1; i <= 2; i++) begin
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy, obs_err} !== {exp_pop, exp_done, exp_busy, exp_err}) begin
            failures++;
            $display("FAIL all_one_model c%0d: pop=%h done=%h busy=%b err=%b want pop=%h done=%h busy=%b err=%b",
                     i, obs_pop, obs_done, obs_busy, obs_err, exp_pop, exp_done, exp_busy, exp_err);
         end
         checks++;
         if (i == 1 && obs_pop !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL all_one_pop: got %h want ffffffff", obs_pop);
         end else if (i == 2 && (obs_done !== 32'hFFFF_FFFF || obs_pop !== 32'h0)) begin
            failures++;
            $display("FAIL all_one_done: done=%h pop=%h want done=ffffffff pop=0", obs_done, obs_pop);
         end
      end
      checks++;
      if (pops[7] !== 1 || pops[31] !== 1) begin
         failures++;
         $display("FAIL all_one_count: lane7=%0d lane31=%0d want 1", pops[7], pops[31]);
      end
   endtask

   task automatic test_empty_hold();
      do_clear();
      s_need[3] = 1'b1; s_nums[3] = 32'd6;
      tick();
      for (int i = 1; i <= 10; i++) begin
         s_emp = (i >= 2 && i <= 4) ? 32'h0000_0008 : 32'h0;
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy, obs_err} !== {exp_pop, exp_done, exp_busy, exp_err}) begin
            failures++;
            $display("FAIL empty_model c%0d: pop=%h done=%h busy=%b want pop=%h done=%h busy=%b",
                     i, obs_pop, obs_done, obs_busy, exp_pop, exp_done, exp_busy);
         end
         checks++;
         if (i == 9 && obs_done[3] !== 1'b0) begin
            failures++;
            $display("FAIL empty_early_done: done[3]=%b at T+9 want 0", obs_done[3]);
         end else if (i == 10 && obs_done[3] !== 1'b1) begin
            failures++;
            $display("FAIL empty_done: done[3]=%b at T+10 want 1", obs_done[3]);
         end
      end
      s_emp = '0;
      checks++;
      if (pops[3] !== 6) begin
         failures++;
         $display("FAIL empty_count: got %0d want 6", pops[3]);
      end
   endtask

   task automatic test_mixed_counts();
      do_clear();
      s_need = '1;
      for (int k = 0; k < N; k++) s_nums[k] = (k >= 30) ? 32'd0 : ((k + 3 > 30) ? 32'd30 : 32'(k + 3));
      tick();
      for (int i = 1; i <= 31; i++) begin
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy} !== {exp_pop, exp_done, exp_busy}) begin
            failures++;
            $display("FAIL mixed_model c%0d: pop=%h done=%h busy=%b want pop=%h done=%h busy=%b",
                     i, obs_pop, obs_done, obs_busy, exp_pop, exp_done, exp_busy);
         end
         if (i == 1) begin
            checks++;
            if (obs_done !== 32'hC000_0000) begin
               failures++;
               $display("FAIL mixed_zero_done: got %h want c0000000", obs_done);
            end
         end else if (i == 30) begin
            checks++;
            if (obs_done[27] !== 1'b0) begin
               failures++;
               $display("FAIL mixed_early: done[27]=%b want 0", obs_done[27]);
            end
         end else if (i == 31) begin
            checks++;
            if (obs_done !== 32'hFFFF_FFFF || obs_busy !== 1'b0) begin
               failures++;
               $display("FAIL mixed_full: done=%h busy=%b want ffffffff 0", obs_done, obs_busy);
            end
         end
      end
      checks++;
      if (pops[0] !== 3 || pops[27] !== 30 || pops[31] !== 0) begin
         failures++;
         $display("FAIL mixed_count: l0=%0d l27=%0d l31=%0d want 3 30 0", pops[0], pops[27], pops[31]);
      end
   endtask

   task automatic test_stall();
      do_clear();
      s_need[5] = 1'b1; s_nums[5] = 32'd5;
      tick();
      for (int i = 1; i <= 10; i++) begin
         s_stall = (i >= 2 && i <= 5);
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy} !== {exp_pop, exp_done, exp_busy}) begin
            failures++;
            $display("FAIL stall_model c%0d: pop=%h done=%h busy=%b want pop=%h done=%h busy=%b",
                     i, obs_pop, obs_done, obs_busy, exp_pop, exp_done, exp_busy);
         end
         checks++;
         if (stall && obs_pop !== 32'h0) begin
            failures++;
            $display("FAIL stall_pop: pop=%h during stall want 0", obs_pop);
         end else if (i == 10 && obs_done[5] !== 1'b1) begin
            failures++;
            $display("FAIL stall_done: done[5]=%b at T+10 want 1", obs_done[5]);
         end
      end
      s_stall = 1'b0;
      checks++;
      if (pops[5] !== 5) begin
         failures++;
         $display("FAIL stall_count: got %0d want 5", pops[5]);
      end
   endtask

   task automatic test_reload_collision();
      do_clear();
      s_need[0] = 1'b1; s_nums[0] = 32'd3;
      tick();
      for (int i = 1; i <= 5; i++) begin
         if (i == 1) begin
            s_need[0] = 1'b1; s_nums[0] = 32'd2;
         end
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy, obs_err} !== {exp_pop, exp_done, exp_busy, exp_err}) begin
            failures++;
            $display("FAIL collide_model c%0d: pop=%h done=%h err=%b want pop=%h done=%h err=%b",
                     i, obs_pop, obs_done, obs_err, exp_pop, exp_done, exp_err);
         end
      end
      checks++;
      if (pops[0] !== 3 || obs_err !== 1'b1 || obs_done[0] !== 1'b1) begin
         failures++;
         $display("FAIL collide_result: pops=%0d err=%b done0=%b want 3 1 1", pops[0], obs_err, obs_done[0]);
      end
      do_clear();
      tick();
      checks++;
      if (obs_err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: err=%b after clear want 1", obs_err);
      end
   endtask

   task automatic test_reset_and_clear();
      do_clear();
      s_need[2] = 1'b1; s_nums[2] = 32'd10;
      tick();
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({fifo_pop, done, busy, err} !== {(2*N+2){1'b0}}) begin
         failures++;
         $display("FAIL midpop_reset: pop=%h done=%h busy=%b err=%b want all 0", fifo_pop, done, busy, err);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      s_clr = 1'b1; s_need = '1;
      for (int k = 0; k < N; k++) s_nums[k] = 32'd4;
      tick();
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy} !== {(2*N+1){1'b0}}) begin
            failures++;
            $display("FAIL clear_wins c%0d: pop=%h done=%h busy=%b want all 0", i, obs_pop, obs_done, obs_busy);
         end
      end
   endtask

   task automatic test_random();
      do_clear();
      for (int i = 0; i < 400; i++) begin
         s_need = $urandom & $urandom & $urandom;
         for (int k = 0; k < N; k++) s_nums[k] = 32'($urandom_range(0, 5));
         s_emp   = $urandom & $urandom;
         s_stall = ($urandom_range(0, 9) == 0);
         s_clr   = ($urandom_range(0, 39) == 0);
         tick();
         checks++;
         if ({obs_pop, obs_done, obs_busy, obs_err} !== {exp_pop, exp_done, exp_busy, exp_err}) begin
            failures++;
            $display("FAIL random c%0d: pop=%h done=%h busy=%b err=%b want pop=%h done=%h busy=%b err=%b",
                     i, obs_pop, obs_done, obs_busy, obs_err, exp_pop, exp_done, exp_busy, exp_err);
         end
      end
      s_emp = '0; s_stall = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_all_one();
      test_empty_hold();
      test_mixed_counts();
      test_stall();
      test_reload_collision();
      test_reset_and_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
